regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Owns the RV32I register-file ports and shares them between the core datapath, a debug requester and a bulk-clear sequencer. In IDLE the core's read and write signals pass straight through. A clear operation or a debug access makes the controller take the ports and assert core_halt. The block sits between the decode/writeback logic and regfile.

Parameters:
REG_COUNT, `REG_COUNT (32), number of architectural registers; x0 is hardwired to zero.
XLEN, `INSTRUCTION_SIZE (32), data width.
AW, $clog2(REG_COUNT), register address width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
core_rs1, core_rs2  in  AW  core read addresses
core_rd  in  AW  core write address
core_we  in  1  core write enable
core_wdata  in  XLEN  core write data
core_halt  out  1  core must stall; high whenever state != IDLE
rf_rs1, rf_rs2, rf_rd  out  AW  to regfile
rf_we  out  1  to regfile
rf_wdata  out  XLEN  to regfile
rf_rdata1  in  XLEN  regfile read_data1 (combinational read)
clear_start  in  1  pulse; request zeroing of x1..x(REG_COUNT-1)
clear_busy  out  1  high in CLEAR
clear_done  out  1  one-cycle pulse after the last clear write
dbg_req_valid  in  1  debug request valid
dbg_req_ready  out  1  debug request accepted
dbg_req_we  in  1  1 = write, 0 = read
dbg_req_addr  in  AW  debug register address
dbg_req_wdata  in  XLEN  debug write data
dbg_rsp_valid  out  1  response valid
dbg_rsp_ready  in  1  response accepted
dbg_rsp_rdata  out  XLEN  read data; 0 for write responses

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, clr_idx=1, captured request cleared, dbg_rsp_rdata=0. Outputs dbg_rsp_valid, clear_busy, clear_done, core_halt and dbg_req_ready are all 0.
- States: IDLE, CLEAR, DBG_ACC, DBG_RESP. core_halt = (state != IDLE), decoded combinationally.
- IDLE:
  - rf_* = core_*, passed through combinationally.
  - dbg_req_ready = !clear_start.
  - clear_start → CLEAR. clear_start has priority over dbg_req_valid when both arrive in the same cycle.
  - dbg_req_valid && dbg_req_ready → latch we/addr/wdata, go to DBG_ACC.
  - A core write in the transition cycle is still passed through.
- CLEAR:
  - rf_we=1, rf_rd=clr_idx, rf_wdata=0; clr_idx increments each cycle.
  - After the clr_idx=REG_COUNT-1 write: → IDLE, clr_idx=1, clear_done=1 for the first IDLE cycle.
  - Duration is exactly REG_COUNT-1 (31) cycles. clear_start and debug requests are ignored during CLEAR.
- DBG_ACC (1 cycle):
  - Write: rf_we=1, rf_rd=addr, rf_wdata=wdata.
  - Read: rf_we=0, rf_rs1=addr; rf_rdata1 is registered into dbg_rsp_rdata.
  - → DBG_RESP.
  - An addr-0 write is issued anyway; the regfile discards it.
- DBG_RESP:
  - dbg_rsp_valid=1, dbg_rsp_rdata held stable.
  - dbg_rsp_ready=1 → IDLE, rsp_valid drops the next cycle. Otherwise hold indefinitely.
- Latency: request accepted in cycle N → regfile access in N+1 → dbg_rsp_valid first high in N+2.
- In any non-IDLE state, core_we is ignored and no core write reaches the regfile; core_rs* are not forwarded.
- Reset mid-operation: immediate return to IDLE with no clear_done and no response. Registers already written stay written.
- Unused rf_rs2 while owned: drives 0.

Decomposition:
- Add REG_COUNT and INSTRUCTION_SIZE usage plus state encodings (`RFC_IDLE..`RFC_DBG_RESP, 2 bits) to RISCV_PKG.vh.
- One sub-module, rf_clear_counter: clr_idx counter with start/last flag, resets to 1.
- Remainder is a single FSM plus output mux.

Test Plan:
- Passthrough: core_we=1, rd=5, wdata=A5A5A5A5, then core_rs1=5 → rf_we=1 in the same cycle, rf_rdata1=A5A5A5A5, core_halt=0 throughout.
- Clear: write x5=A5A5A5A5 and x10=12345678, then pulse clear_start → clear_busy and core_halt high for exactly 31 cycles, rf_rd sequence 1..31 with wdata 0, a single clear_done pulse; afterwards x5=0 and x10=0.
- Debug write then read: write x15=87654321, then read x15 → dbg_rsp_valid at accept+2; read response dbg_rsp_rdata=87654321; write response rdata=0.
- x0 protection: debug write x0=FFFFFFFF, then debug read x0 → dbg_rsp_rdata=00000000.
- Collision and backpressure:
  - clear_start and dbg_req_valid in the same IDLE cycle → dbg_req_ready=0, clear runs first; debug request accepted in the cycle clear_done is high.
  - Hold dbg_rsp_ready=0 for 3 cycles → dbg_rsp_valid and dbg_rsp_rdata stay stable.
- Reset mid-clear: assert rst=0 asynchronously at clr_idx=10 → state IDLE and clear_busy/core_halt=0 without a clock edge, no clear_done; x11..x31 retain their values.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_pkg
//    Shared constants and state encoding for the register-file access
//    controller.
//    REG_COUNT        : number of architectural registers (x0 hardwired to 0)
//    INSTRUCTION_SIZE : machine word width, used as XLEN
//    AW               : register address width
//    rfc_state_e      : controller ownership states
// ---------------------------------------------------------------------------
package regfile_access_ctrl_pkg;

   localparam int REG_COUNT        = 32;
   localparam int INSTRUCTION_SIZE = 32;
   localparam int XLEN             = INSTRUCTION_SIZE;
   localparam int AW               = $clog2(REG_COUNT);

   typedef enum logic [1:0] {
      RFC_IDLE     = 2'd0,
      RFC_CLEAR    = 2'd1,
      RFC_DBG_ACC  = 2'd2,
      RFC_DBG_RESP = 2'd3
   } rfc_state_e;

endpackage

// File: rtl/regfile_access_ctrl_clear_counter.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_clear_counter
//    Register index walker for the bulk-clear sequence. Sits at 1 when idle,
//    steps once per advance, and wraps back to 1 after REG_COUNT-1 so the
//    next clear needs no extra setup.
//    clk     : system clock
//    rst     : asynchronous active-low reset (index returns to 1)
//    start   : reload the index to 1
//    advance : step to the next register
//    clr_idx : register currently being cleared
//    last    : clr_idx is the final register (REG_COUNT-1)
// ---------------------------------------------------------------------------
module regfile_access_ctrl_clear_counter #(
   parameter int REG_COUNT = 32,
   parameter int AW        = $clog2(REG_COUNT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          advance,
   output logic [AW-1:0] clr_idx,
   output logic          last
);

   localparam logic [AW-1:0] FIRST_IDX = AW'(1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(REG_COUNT - 1);

   logic [AW-1:0] clr_idx_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clr_idx_reg <= FIRST_IDX;
      end else if (start) begin
         clr_idx_reg <= FIRST_IDX;
      end else if (advance) begin
         clr_idx_reg <= last ? FIRST_IDX : clr_idx_reg + FIRST_IDX;
      end
   end

   assign clr_idx = clr_idx_reg;
   assign last    = (clr_idx_reg == LAST_IDX);

endmodule

// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//    Arbitrates the RV32I register-file ports between the core datapath, a
//    debug requester and a bulk-clear sequencer. In IDLE the core ports pass
//    straight through; clear and debug operations take the ports over and
//    stall the core via core_halt.
//    clk, rst                : clock, asynchronous active-low reset
//    core_rs1/rs2/rd/we/wdata: core register-file requests
//    core_halt               : core must stall (controller owns the ports)
//    rf_*                    : register-file ports (combinational read data)
//    clear_start/busy/done   : bulk-clear of x1..x(REG_COUNT-1)
//    dbg_req_* / dbg_rsp_*   : single-beat debug read/write, valid/ready
// ---------------------------------------------------------------------------
import regfile_access_ctrl_pkg::*;

module regfile_access_ctrl #(
   parameter int REG_COUNT = regfile_access_ctrl_pkg::REG_COUNT,
   parameter int XLEN      = regfile_access_ctrl_pkg::XLEN,
   parameter int AW        = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   core_rs1,
   input  logic [AW-1:0]   core_rs2,
   input  logic [AW-1:0]   core_rd,
   input  logic            core_we,
   input  logic [XLEN-1:0] core_wdata,
   output logic            core_halt,
   output logic [AW-1:0]   rf_rs1,
   output logic [AW-1:0]   rf_rs2,
   output logic [AW-1:0]   rf_rd,
   output logic            rf_we,
   output logic [XLEN-1:0] rf_wdata,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic            clear_start,
   output logic            clear_busy,
   output logic            clear_done,
   input  logic            dbg_req_valid,
   output logic            dbg_req_ready,
   input  logic            dbg_req_we,
   input  logic [AW-1:0]   dbg_req_addr,
   input  logic [XLEN-1:0] dbg_req_wdata,
   output logic            dbg_rsp_valid,
   input  logic            dbg_rsp_ready,
   output logic [XLEN-1:0] dbg_rsp_rdata
);

   rfc_state_e      state_reg, state_next;
   logic            req_we_reg;
   logic [AW-1:0]   req_addr_reg;
   logic [XLEN-1:0] req_wdata_reg;
   logic [XLEN-1:0] rsp_rdata_reg;
   logic            clear_done_reg;

   logic            req_accept;
   logic            clr_start;
   logic            clr_advance;
   logic [AW-1:0]   clr_idx;
   logic            clr_last;

   regfile_access_ctrl_clear_counter #(
      .REG_COUNT (REG_COUNT),
      .AW        (AW)
   ) u_clear_counter (
      .clk     (clk),
      .rst     (rst),
      .start   (clr_start),
      .advance (clr_advance),
      .clr_idx (clr_idx),
      .last    (clr_last)
   );

   // Next-state and port mux. Owned states drive unused read ports to 0 so
   // nothing from the stalled core leaks into the regfile.
   always_comb begin
      state_next    = state_reg;
      rf_rs1        = '0;
      rf_rs2        = '0;
      rf_rd         = '0;
      rf_we         = 1'b0;
      rf_wdata      = '0;
      dbg_req_ready = 1'b0;
      req_accept    = 1'b0;
      clr_start     = 1'b0;
      clr_advance   = 1'b0;

      case (state_reg)
         RFC_IDLE: begin
            rf_rs1   = core_rs1;
            rf_rs2   = core_rs2;
            rf_rd    = core_rd;
            rf_we    = core_we;
            rf_wdata = core_wdata;
            // Clear wins a same-cycle collision; ready is also held low
            // while reset is asserted so nothing is accepted then.
            dbg_req_ready = rst & ~clear_start;
            if (clear_start) begin
               state_next = RFC_CLEAR;
               clr_start  = 1'b1;
            end else if (dbg_req_valid) begin
               state_next = RFC_DBG_ACC;
               req_accept = 1'b1;
            end
         end
         RFC_CLEAR: begin
            rf_we       = 1'b1;
            rf_rd       = clr_idx;
            clr_advance = 1'b1;
            if (clr_last) begin
               state_next = RFC_IDLE;
            end
         end
         RFC_DBG_ACC: begin
            // Address 0 writes are issued as-is; the regfile ignores them.
            if (req_we_reg) begin
               rf_we    = 1'b1;
               rf_rd    = req_addr_reg;
               rf_wdata = req_wdata_reg;
            end else begin
               rf_rs1 = req_addr_reg;
            end
            state_next = RFC_DBG_RESP;
         end
         RFC_DBG_RESP: begin
            if (dbg_rsp_ready) begin
               state_next = RFC_IDLE;
            end
         end
         default: begin
            state_next = RFC_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= RFC_IDLE;
         req_we_reg     <= 1'b0;
         req_addr_reg   <= '0;
         req_wdata_reg  <= '0;
         rsp_rdata_reg  <= '0;
         clear_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         // Pulses in the first IDLE cycle after the final clear write.
         clear_done_reg <= (state_reg == RFC_CLEAR) && clr_last;
         if (req_accept) begin
            req_we_reg    <= dbg_req_we;
            req_addr_reg  <= dbg_req_addr;
            req_wdata_reg <= dbg_req_wdata;
         end
         if (state_reg == RFC_DBG_ACC) begin
            rsp_rdata_reg <= req_we_reg ? '0 : rf_rdata1;
         end
      end
   end

   assign core_halt     = (state_reg != RFC_IDLE);
   assign clear_busy    = (state_reg == RFC_CLEAR);
   assign clear_done    = clear_done_reg;
   assign dbg_rsp_valid = (state_reg == RFC_DBG_RESP);
   assign dbg_rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

   localparam int REG_COUNT = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  core_rs1 = '0, core_rs2 = '0, core_rd = '0;
   logic        core_we = 1'b0;
   logic [31:0] core_wdata = '0;
   logic        core_halt;
   logic [4:0]  rf_rs1, rf_rs2, rf_rd;
   logic        rf_we;
   logic [31:0] rf_wdata, rf_rdata1;
   logic        clear_start = 1'b0;
   logic        clear_busy, clear_done;
   logic        dbg_req_valid = 1'b0;
   logic        dbg_req_ready;
   logic        dbg_req_we = 1'b0;
   logic [4:0]  dbg_req_addr = '0;
   logic [31:0] dbg_req_wdata = '0;
   logic        dbg_rsp_valid;
   logic        dbg_rsp_ready = 1'b0;
   logic [31:0] dbg_rsp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_access_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .core_rs1      (core_rs1),
      .core_rs2      (core_rs2),
      .core_rd       (core_rd),
      .core_we       (core_we),
      .core_wdata    (core_wdata),
      .core_halt     (core_halt),
      .rf_rs1        (rf_rs1),
      .rf_rs2        (rf_rs2),
      .rf_rd         (rf_rd),
      .rf_we         (rf_we),
      .rf_wdata      (rf_wdata),
      .rf_rdata1     (rf_rdata1),
      .clear_start   (clear_start),
      .clear_busy    (clear_busy),
      .clear_done    (clear_done),
      .dbg_req_valid (dbg_req_valid),
      .dbg_req_ready (dbg_req_ready),
      .dbg_req_we    (dbg_req_we),
      .dbg_req_addr  (dbg_req_addr),
      .dbg_req_wdata (dbg_req_wdata),
      .dbg_rsp_valid (dbg_rsp_valid),
      .dbg_rsp_ready (dbg_rsp_ready),
      .dbg_rsp_rdata (dbg_rsp_rdata)
   );

   // Simple regfile in the environment: x0 hardwired, combinational read.
   logic [31:0] regs [REG_COUNT];
   initial for (int i = 0; i < REG_COUNT; i++) regs[i] = '0;
   always @(posedge clk) if (rf_we && rf_rd != 5'd0) regs[rf_rd] <= rf_wdata;
   assign rf_rdata1 = regs[rf_rs1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Ownership is tracked as "clear writes still owed" and "debug phase"
   // (0 none, 1 access, 2 response); m_arch is the architectural view.
   int          m_left  = 0;
   int          m_phase = 0;
   bit          m_done  = 0;
   logic [31:0] m_rsp   = '0;
   bit          m_we    = 0;
   logic [4:0]  m_addr  = '0;
   logic [31:0] m_wd    = '0;
   logic [31:0] m_arch [REG_COUNT];
   bit          e_idle;
   initial for (int i = 0; i < REG_COUNT; i++) m_arch[i] = '0;

   always @(negedge clk) begin
      if (!rst) begin
         m_left = 0; m_phase = 0; m_done = 0; m_rsp = '0;
      end else begin
         e_idle = (m_left == 0) && (m_phase == 0);
         chk("core_halt", core_halt, !e_idle);
         chk("clear_busy", clear_busy, m_left != 0);
         chk("clear_done", clear_done, m_done);
         chk("dbg_req_ready", dbg_req_ready, e_idle && !clear_start);
         chk("dbg_rsp_valid", dbg_rsp_valid, m_phase == 2);
         chk("rf_rs2", rf_rs2, e_idle ? core_rs2 : 5'd0);
         if (e_idle) begin
            chk("pass_we", rf_we, core_we);
            if (core_we) begin
               chk("pass_rd", rf_rd, core_rd);
               chk("pass_wdata", rf_wdata, core_wdata);
            end
            chk("pass_rs1", rf_rs1, core_rs1);
            chk("arch_read", rf_rdata1, m_arch[core_rs1]);
            m_done = 0;
            if (core_we && core_rd != 5'd0) m_arch[core_rd] = core_wdata;
            if (clear_start) m_left = REG_COUNT - 1;
            else if (dbg_req_valid) begin
               m_we = dbg_req_we; m_addr = dbg_req_addr; m_wd = dbg_req_wdata;
               m_phase = 1;
            end
         end else if (m_left != 0) begin
            chk("clr_we", rf_we, 1);
            chk("clr_rd", rf_rd, REG_COUNT - m_left);
            chk("clr_wdata", rf_wdata, 0);
            m_arch[REG_COUNT - m_left] = '0;
            m_left--;
            if (m_left == 0) m_done = 1;
         end else if (m_phase == 1) begin
            if (m_we) begin
               chk("acc_we", rf_we, 1);
               chk("acc_rd", rf_rd, m_addr);
               chk("acc_wdata", rf_wdata, m_wd);
               if (m_addr != 5'd0) m_arch[m_addr] = m_wd;
               m_rsp = '0;
            end else begin
               chk("acc_we", rf_we, 0);
               chk("acc_rs1", rf_rs1, m_addr);
               m_rsp = m_arch[m_addr];
            end
            m_phase = 2;
         end else begin
            chk("resp_we", rf_we, 0);
            chk("resp_rdata", dbg_rsp_rdata, m_rsp);
            if (dbg_rsp_ready) m_phase = 0;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic core_write(input logic [4:0] rd, input logic [31:0] wd);
      @(posedge clk); #1;
      core_we = 1; core_rd = rd; core_wdata = wd;
      @(negedge clk);
      chk("cw_rf_we", rf_we, 1);
      chk("cw_rf_rd", rf_rd, rd);
      chk("cw_rf_wdata", rf_wdata, wd);
      chk("cw_halt", core_halt, 0);
      @(posedge clk); #1;
      core_we = 0;
   endtask

   task automatic core_read(input logic [4:0] rs, input logic [31:0] exp);
      @(posedge clk); #1;
      core_rs1 = rs;
      @(negedge clk);
      chk("cr_rdata", rf_rdata1, exp);
      chk("cr_halt", core_halt, 0);
   endtask

   task automatic dbg_txn(input bit we, input logic [4:0] addr, input logic [31:0] wd,
                          input int hold, input bit with_clear, output logic [31:0] rd);
      int waited, lat;
      @(posedge clk); #1;
      dbg_req_valid = 1; dbg_req_we = we; dbg_req_addr = addr; dbg_req_wdata = wd;
      clear_start = with_clear;
      if (with_clear) begin
         @(negedge clk);
         chk("collide_ready", dbg_req_ready, 0);
         @(posedge clk); #1;
         clear_start = 0;
      end
      waited = 0;
      @(negedge clk);
      while (!dbg_req_ready && waited < 50) begin waited++; @(negedge clk); end
      chk("accept_timeout", waited < 50, 1);
      if (with_clear) chk("accept_in_done_cycle", clear_done, 1);
      @(posedge clk); #1;
      dbg_req_valid = 0;
      lat = 1;
      @(negedge clk);
      while (!dbg_rsp_valid && lat < 10) begin lat++; @(negedge clk); end
      chk("rsp_latency", lat, 2);
      rd = dbg_rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", dbg_rsp_valid, 1);
         chk("hold_rdata", dbg_rsp_rdata, rd);
      end
      @(posedge clk); #1;
      dbg_rsp_ready = 1;
      @(posedge clk); #1;
      dbg_rsp_ready = 0;
      @(negedge clk);
      chk("rsp_drop", dbg_rsp_valid, 0);
      $display("txn dbg we=%0d addr=%0d wdata=%h rdata=%h", we, addr, wd, rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int busy_cnt, done_cnt, waited;

      // Reset state
      #3;
      chk("rst_halt", core_halt, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_ready", dbg_req_ready, 0);
      chk("rst_rsp_valid", dbg_rsp_valid, 0);
      chk("rst_rsp_rdata", dbg_rsp_rdata, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1;

      // Passthrough
      core_write(5'd5, 32'hA5A5A5A5);
      core_read(5'd5, 32'hA5A5A5A5);
      core_write(5'd10, 32'h12345678);
      $display("txn core write x5/x10 and read x5");

      // Bulk clear
      @(posedge clk); #1;
      clear_start = 1;
      @(posedge clk); #1;
      clear_start = 0;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (clear_busy) begin
            busy_cnt++;
            chk("clr_seq_rd", rf_rd, busy_cnt);
            chk("clr_seq_halt", core_halt, 1);
         end
         if (clear_done) done_cnt++;
      end
      chk("clr_cycles", busy_cnt, 31);
      chk("clr_done_pulses", done_cnt, 1);
      chk("clr_x5", regs[5], 0);
      chk("clr_x10", regs[10], 0);
      $display("txn clear busy=%0d done=%0d", busy_cnt, done_cnt);

      // Debug write/read, x0 protection
      dbg_txn(1, 5'd15, 32'h87654321, 0, 0, rd);
      chk("dbg_wr_rdata", rd, 0);
      dbg_txn(0, 5'd15, 32'h0, 0, 0, rd);
      chk("dbg_rd_x15", rd, 32'h87654321);
      dbg_txn(1, 5'd0, 32'hFFFFFFFF, 0, 0, rd);
      dbg_txn(0, 5'd0, 32'h0, 0, 0, rd);
      chk("dbg_rd_x0", rd, 0);

      // Collision with clear, then backpressured read
      dbg_txn(1, 5'd20, 32'hCAFEF00D, 0, 1, rd);
      dbg_txn(0, 5'd20, 32'h0, 3, 0, rd);
      chk("dbg_rd_x20", rd, 32'hCAFEF00D);

      // Reset in the middle of a clear
      for (int i = 1; i < REG_COUNT; i++) core_write(5'(i), 32'h1000 + i);
      @(posedge clk); #1;
      clear_start = 1;
      @(posedge clk); #1;
      clear_start = 0;
      waited = 0;
      @(negedge clk);
      while (!(clear_busy && rf_rd == 5'd9) && waited < 40) begin waited++; @(negedge clk); end
      chk("mid_clear_reach", waited < 40, 1);
      @(posedge clk); #2;
      rst = 0;
      #1;
      chk("mid_rst_halt", core_halt, 0);
      chk("mid_rst_busy", clear_busy, 0);
      chk("mid_rst_done", clear_done, 0);
      chk("mid_rst_rsp_valid", dbg_rsp_valid, 0);
      chk("mid_rst_we", rf_we, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      done_cnt = 0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (clear_done) done_cnt++;
      end
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_x9", regs[9], 0);
      chk("mid_rst_x11", regs[11], 32'h100B);
      chk("mid_rst_x31", regs[31], 32'h101F);
      $display("txn reset during clear at index 10");

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         core_we       = 1'($urandom_range(0, 1));
         core_rd       = 5'($urandom);
         core_rs1      = 5'($urandom);
         core_rs2      = 5'($urandom);
         core_wdata    = $urandom;
         clear_start   = ($urandom_range(0, 79) == 0);
         dbg_req_valid = ($urandom_range(0, 2) == 0);
         dbg_req_we    = 1'($urandom_range(0, 1));
         dbg_req_addr  = 5'($urandom);
         dbg_req_wdata = $urandom;
         dbg_rsp_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      core_we = 0; clear_start = 0; dbg_req_valid = 0; dbg_rsp_ready = 1;
      repeat (40) @(posedge clk);
      #1 dbg_rsp_ready = 0;
      @(negedge clk);
      for (int i = 0; i < REG_COUNT; i++) chk("final_reg", regs[i], m_arch[i]);
      $display("txn random phase complete");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
